hazard_sched: RTL and testbench

- Sequential stall/flush scheduler for the five-stage RISC-V IMV pipeline.
- Supersedes the purely combinational load-use stall logic.
- Sequences multi-cycle multiply/divide occupancy of EX, freezes the whole pipe on data-memory wait, and squashes IF/ID and ID/EX on a taken branch resolved in EX.
- Drives every pipeline-register stall, bubble and flush control.

---
 rtl/hazard_sched.sv | 130 +++++++++++++
 tb/tb_hazard_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// Stall/flush scheduler for the five-stage pipeline: sequences multiply/divide
// EX occupancy, freezes the pipe on data-memory wait and squashes on taken branch.
module hazard_sched #(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 33,
   parameter int CNT_W   = 6,
   parameter int MEM_TO  = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load_use_hazard,
   input  logic ex_mul_start,
   input  logic ex_div_start,
   input  logic branch_taken,
   input  logic dmem_req,
   input  logic dmem_ready,
   output logic pc_stall,
   output logic ifid_stall,
   output logic idex_stall,
   output logic exmem_bubble,
   output logic exmem_stall,
   output logic memwb_stall,
   output logic ifid_flush,
   output logic idex_flush,
   output logic md_busy,
   output logic md_done,
   output logic mem_timeout
);

   typedef enum logic [0:0] {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [7:0]       memwait_r;
   logic             freeze_s;

   assign freeze_s = dmem_req & ~dmem_ready;
   assign md_busy  = (state_r == MD_BUSY);

   // Pipeline control decode, highest priority first
   always_comb begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      idex_stall   = 1'b0;
      exmem_bubble = 1'b0;
      exmem_stall  = 1'b0;
      memwb_stall  = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      md_done      = 1'b0;
      if (rst) begin
         md_done = 1'b0;
      end else if (freeze_s) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
         memwb_stall = 1'b1;
      end else if (state_r == MD_BUSY) begin
         if (cnt_r == CNT_W'(1)) begin
            md_done = 1'b1;
         end else begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_bubble = 1'b1;
         end
      end else if (ex_div_start || ex_mul_start || !branch_taken && load_use_hazard) begin
         pc_stall     = 1'b1;
         ifid_stall   = 1'b1;
         idex_stall   = 1'b1;
         exmem_bubble = 1'b1;
      end else if (branch_taken) begin
         // A simultaneous load-use is moot: the dependent instruction is squashed
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else begin
         md_done = 1'b0;
      end
   end

   // Occupancy sequencer and memory-wait watchdog; a freeze holds the sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         memwait_r   <= 8'd0;
         mem_timeout <= 1'b0;
      end else if (freeze_s) begin
         if (memwait_r != 8'hFF) begin
            memwait_r <= memwait_r + 8'd1;
         end else begin
            memwait_r <= memwait_r;
         end
         if (memwait_r >= 8'(MEM_TO - 1)) begin
            mem_timeout <= 1'b1;
         end else begin
            mem_timeout <= mem_timeout;
         end
      end else begin
         memwait_r <= 8'd0;
         case (state_r)
            IDLE: begin
               if (ex_div_start) begin
                  state_r <= MD_BUSY;
                  cnt_r   <= CNT_W'(DIV_LAT - 1);
               end else if (ex_mul_start) begin
                  state_r <= MD_BUSY;
                  cnt_r   <= CNT_W'(MUL_LAT - 1);
               end else begin
                  state_r <= IDLE;
               end
            end
            MD_BUSY: begin
               if (cnt_r == CNT_W'(1)) begin
                  state_r <= IDLE;
                  cnt_r   <= {CNT_W{1'b0}};
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed vector table, multi-cycle
// corner sequences and randomized traffic against a cycle-count reference model.
module tb_hazard_sched;

   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 33;
   localparam int CNT_W   = 6;
   localparam int MEM_TO  = 255;

   // Output vector bit order:
   // {pc,ifid,idex,bubble,exmem_stall,memwb_stall,ifid_fl,idex_fl,busy,done,timeout}
   localparam logic [10:0] O_ZERO = 11'b00000000000;
   localparam logic [10:0] O_STB  = 11'b11110000000;
   localparam logic [10:0] O_FRZ  = 11'b11101100000;
   localparam logic [10:0] O_FLS  = 11'b00000011000;
   localparam logic [10:0] O_BUSY = 11'b00000000100;
   localparam logic [10:0] O_DONE = 11'b00000000010;

   logic clk = 1'b0;
   logic rst, load_use_hazard, ex_mul_start, ex_div_start, branch_taken, dmem_req, dmem_ready;
   logic pc_stall, ifid_stall, idex_stall, exmem_bubble, exmem_stall, memwb_stall;
   logic ifid_flush, idex_flush, md_busy, md_done, mem_timeout;
   logic [10:0] outs_s;

   int checks = 0;
   int failures = 0;

   // Reference model state: operation in progress, its latency, EX cycles used
   bit m_active;
   int m_lat;
   int m_prog;
   int m_run;
   bit m_to;

   hazard_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W), .MEM_TO(MEM_TO)) dut (
      .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard),
      .ex_mul_start(ex_mul_start), .ex_div_start(ex_div_start),
      .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
      .exmem_bubble(exmem_bubble), .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .md_busy(md_busy),
      .md_done(md_done), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   assign outs_s = {pc_stall, ifid_stall, idex_stall, exmem_bubble, exmem_stall, memwb_stall,
                    ifid_flush, idex_flush, md_busy, md_done, mem_timeout};

   function automatic logic [10:0] model_out();
      logic [10:0] o;
      bit frz;
      frz = dmem_req && !dmem_ready;
      o = O_ZERO;
      if (!rst) begin
         if (frz) o = O_FRZ;
         else if (m_active) o = (m_prog == m_lat - 1) ? O_DONE : O_STB;
         else if (ex_div_start || ex_mul_start) o = O_STB;
         else if (branch_taken) o = O_FLS;
         else if (load_use_hazard) o = O_STB;
      end
      o[2] = m_active;
      o[0] = m_to;
      return o;
   endfunction

   task automatic model_edge();
      bit frz;
      frz = dmem_req && !dmem_ready;
      if (rst) begin
         m_active = 1'b0; m_prog = 0; m_run = 0; m_to = 1'b0;
      end else if (frz) begin
         m_run++;
         if (m_run >= MEM_TO) m_to = 1'b1;
      end else begin
         m_run = 0;
         if (m_active) begin
            if (m_prog == m_lat - 1) m_active = 1'b0;
            else m_prog++;
         end else if (ex_div_start) begin
            m_active = 1'b1; m_lat = DIV_LAT; m_prog = 1;
         end else if (ex_mul_start) begin
            m_active = 1'b1; m_lat = MUL_LAT; m_prog = 1;
         end
      end
   endtask

   task automatic set_in(input logic [6:0] v);
      {rst, load_use_hazard, ex_mul_start, ex_div_start, branch_taken, dmem_req, dmem_ready} = v;
   endtask

   // Sample mid-cycle, advance the model with the same inputs, step one clock
   task automatic tick(output logic [10:0] act, output logic [10:0] mod);
      #3;
      act = outs_s;
      mod = model_out();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   task automatic check_int(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   typedef struct {
      logic [6:0]  in;   // {rst,lu,mul,div,br,req,rdy}
      logic [10:0] exp;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [10:0] a, m;
      int done_at;

      tbl[0]  = '{7'b1100100, O_ZERO};
      tbl[1]  = '{7'b0000000, O_ZERO};
      tbl[2]  = '{7'b0100100, O_FLS};
      tbl[3]  = '{7'b0100000, O_STB};
      tbl[4]  = '{7'b0000000, O_ZERO};
      tbl[5]  = '{7'b0010000, O_STB};
      tbl[6]  = '{7'b0000100, O_STB | O_BUSY};
      tbl[7]  = '{7'b0000000, O_DONE | O_BUSY};
      tbl[8]  = '{7'b0000000, O_ZERO};
      tbl[9]  = '{7'b0100010, O_FRZ};
      tbl[10] = '{7'b0000011, O_ZERO};
      tbl[11] = '{7'b0011100, O_STB};
      tbl[12] = '{7'b0000010, O_FRZ | O_BUSY};
      tbl[13] = '{7'b0000000, O_STB | O_BUSY};

      m_active = 1'b0; m_lat = 0; m_prog = 0; m_run = 0; m_to = 1'b0;
      set_in(7'b1000000);
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         set_in(tbl[i].in);
         tick(a, m);
         check($sformatf("vec%0d", i), a, tbl[i].exp);
      end

      // Divide with a four-cycle freeze starting when cnt would be 10
      set_in(7'b1000000);
      tick(a, m);
      done_at = -1;
      for (int k = 0; k < 46; k++) begin
         set_in({1'b0, 1'b0, 1'b0, k == 0, 1'b0, k >= 23 && k <= 26, 1'b0});
         tick(a, m);
         check($sformatf("div_frz_k%0d", k), a, m);
         if (k == 23) check("div_frz_hold", a, O_FRZ | O_BUSY);
         if (a[1] && done_at < 0) done_at = k;
      end
      check_int("div_done_cycle", done_at, DIV_LAT - 1 + 4);

      // Memory wait timeout: sticky until reset
      set_in(7'b1000000);
      tick(a, m);
      for (int k = 0; k < 256; k++) begin
         set_in(7'b0000010);
         tick(a, m);
         if (k % 32 == 0) check($sformatf("memwait_k%0d", k), a, m);
         if (k == 254) check("timeout_pre", {10'd0, a[0]}, 11'd0);
         if (k == 255) check("timeout_rise", {10'd0, a[0]}, 11'd1);
      end
      for (int k = 0; k < 5; k++) begin
         set_in(7'b0000011);
         tick(a, m);
         check($sformatf("timeout_sticky%0d", k), a, O_ZERO | 11'd1);
      end
      set_in(7'b1000011);
      tick(a, m);
      check("timeout_rst_cycle", a, m);
      set_in(7'b0000000);
      tick(a, m);
      check("timeout_cleared", a, O_ZERO);

      // Reset in the middle of a divide, then a clean multiply
      set_in(7'b0001000);
      tick(a, m);
      for (int k = 1; k < 13; k++) begin
         set_in(7'b0000000);
         tick(a, m);
      end
      set_in(7'b1001100);
      tick(a, m);
      check("rst_mid_div", a, O_BUSY);
      for (int k = 0; k < 40; k++) begin
         set_in(7'b0000000);
         tick(a, m);
         if (k < 3 || k == 39) check($sformatf("post_rst_idle%0d", k), a, O_ZERO);
      end
      set_in(7'b0010000);
      tick(a, m);
      check("mul_after_rst_start", a, O_STB);
      set_in(7'b0000000);
      tick(a, m);
      check("mul_after_rst_busy", a, O_STB | O_BUSY);
      tick(a, m);
      check("mul_after_rst_done", a, O_DONE | O_BUSY);
      tick(a, m);
      check("mul_after_rst_idle", a, O_ZERO);

      // Randomized traffic against the reference model
      for (int k = 0; k < 3000; k++) begin
         logic r, lu, mu, dv, br, rq, rd;
         r  = ($urandom_range(0, 63) == 0);
         lu = ($urandom_range(0, 3) == 0);
         mu = ($urandom_range(0, 7) == 0);
         dv = ($urandom_range(0, 31) == 0);
         br = !(mu || dv) && ($urandom_range(0, 4) == 0);
         rq = ($urandom_range(0, 2) == 0);
         rd = ($urandom_range(0, 1) == 0);
         set_in({r, lu, mu, dv, br, rq, rd});
         tick(a, m);
         check($sformatf("rand%0d", k), a, m);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
